// File: rtl/parking_lot_if.sv
// Request/status bundle between the sensor debouncers (master) and the
// parking controller (slave).
//
// Handshake: entry_req and exit_req are single-cycle pulses with no ready
// signal.  The controller samples them only while it is idle and answers one
// cycle later with exactly one of entry_ack/entry_rej or exit_ack/exit_err.
// A request that gets no answer was dropped because the door was busy.
interface parking_lot_if #(
   parameter int LEVELS = 4,
   parameter int SLOTS  = 8
);
   localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int TW = $clog2(LEVELS * SLOTS + 1);

   logic              entry_req;
   logic              exit_req;
   logic [LW-1:0]     exit_level;
   logic              door_open;
   logic              full;
   logic [LEVELS-1:0] level_full;
   logic [LW-1:0]     assigned_level;
   logic [TW-1:0]     occupancy;
   logic              entry_ack;
   logic              entry_rej;
   logic              exit_ack;
   logic              exit_err;
   logic [1:0]        state;

   modport master (
      output entry_req, exit_req, exit_level,
      input  door_open, full, level_full, assigned_level, occupancy,
      input  entry_ack, entry_rej, exit_ack, exit_err, state
   );

   modport slave (
      input  entry_req, exit_req, exit_level,
      output door_open, full, level_full, assigned_level, occupancy,
      output entry_ack, entry_rej, exit_ack, exit_err, state
   );
endinterface

// File: rtl/parking_lot_ctrl.sv
// Multi-level parking controller: allocates entering cars to the lowest level
// with a free slot, tracks per-level and total occupancy, and runs a timed door.
module parking_lot_ctrl #(
   parameter int LEVELS      = 4,
   parameter int SLOTS       = 8,
   parameter int DOOR_CYCLES = 1000
) (
   input logic           clk,
   input logic           reset,
   parking_lot_if.slave  bus
);
   localparam int LW  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int CW  = $clog2(SLOTS + 1);
   localparam int TW  = $clog2(LEVELS * SLOTS + 1);
   localparam int TMW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   localparam logic [TW-1:0]  TOTAL = TW'(LEVELS * SLOTS);
   localparam logic [CW-1:0]  CAP   = CW'(SLOTS);
   // The door is already open during the cycle the timer is loaded, so it
   // counts down from DOOR_CYCLES-1 and closes on the edge after reaching 0.
   localparam logic [TMW-1:0] TLOAD = TMW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2
   } state_t;

   state_t         r_state;
   logic [TMW-1:0] r_timer;
   logic           r_door;
   logic [LW-1:0]  r_assigned;
   logic           r_entry_ack;
   logic           r_entry_rej;
   logic           r_exit_ack;
   logic           r_exit_err;
   logic [CW-1:0]  r_count [LEVELS];
   logic [TW-1:0]  r_occupancy;

   logic              w_free_found;
   logic [LW-1:0]     w_free_idx;
   logic [CW-1:0]     w_exit_cnt;
   logic              w_exit_ok;
   logic              w_full;
   logic              w_do_entry;
   logic              w_do_exit;
   logic [LEVELS-1:0] w_level_full;

   // Lowest-numbered level that still has a free slot (scan high to low so
   // the last hit, the lowest index, wins).
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = LEVELS - 1; i >= 0; i--) begin
         if (r_count[i] != CAP) begin
            w_free_found = 1'b1;
            w_free_idx   = LW'(i);
         end
      end
   end

   // Count on the exiting level; an out-of-range level matches nothing and
   // reads as 0, so it falls into the same error path as an empty level.
   always_comb begin
      w_exit_cnt = '0;
      for (int i = 0; i < LEVELS; i++) begin
         if (bus.exit_level == LW'(i)) w_exit_cnt = r_count[i];
      end
   end

   // Per-level full flags decoded from the registered counters.
   always_comb begin
      w_level_full = '0;
      for (int i = 0; i < LEVELS; i++) begin
         w_level_full[i] = (r_count[i] == CAP);
      end
   end

   assign w_exit_ok  = (w_exit_cnt != '0);
   assign w_full     = (r_occupancy == TOTAL);
   // Exit has priority over a simultaneous entry; requests outside IDLE drop.
   assign w_do_exit  = (r_state == IDLE) && bus.exit_req && w_exit_ok;
   assign w_do_entry = (r_state == IDLE) && !bus.exit_req && bus.entry_req && w_free_found;

   // Level counters and total occupancy, moved by exactly one per accepted event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LEVELS; i++) r_count[i] <= '0;
         r_occupancy <= '0;
      end else begin
         for (int i = 0; i < LEVELS; i++) begin
            if (w_do_exit && (bus.exit_level == LW'(i))) begin
               r_count[i] <= r_count[i] - 1'b1;
            end else if (w_do_entry && (w_free_idx == LW'(i))) begin
               r_count[i] <= r_count[i] + 1'b1;
            end
         end
         if (w_do_exit) begin
            r_occupancy <= r_occupancy - 1'b1;
         end else if (w_do_entry) begin
            r_occupancy <= r_occupancy + 1'b1;
         end
      end
   end

   // Gate FSM with registered door, status pulses and assigned level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_timer     <= '0;
         r_door      <= 1'b0;
         r_assigned  <= '0;
         r_entry_ack <= 1'b0;
         r_entry_rej <= 1'b0;
         r_exit_ack  <= 1'b0;
         r_exit_err  <= 1'b0;
      end else begin
         r_entry_ack <= 1'b0;
         r_entry_rej <= 1'b0;
         r_exit_ack  <= 1'b0;
         r_exit_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.exit_req) begin
                  if (w_exit_ok) begin
                     r_exit_ack <= 1'b1;
                     r_state    <= EXIT_OPEN;
                     r_door     <= 1'b1;
                     r_timer    <= TLOAD;
                  end else begin
                     r_exit_err <= 1'b1;
                  end
               end else if (bus.entry_req) begin
                  if (w_free_found) begin
                     r_entry_ack <= 1'b1;
                     r_assigned  <= w_free_idx;
                     r_state     <= ENTRY_OPEN;
                     r_door      <= 1'b1;
                     r_timer     <= TLOAD;
                  end else begin
                     r_entry_rej <= 1'b1;
                  end
               end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
               if (r_timer == '0) begin
                  r_state <= IDLE;
                  r_door  <= 1'b0;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_door  <= 1'b0;
               r_timer <= '0;
            end
         endcase
      end
   end

   assign bus.door_open      = r_door;
   assign bus.full           = w_full;
   assign bus.level_full     = w_level_full;
   assign bus.assigned_level = r_assigned;
   assign bus.occupancy      = r_occupancy;
   assign bus.entry_ack      = r_entry_ack;
   assign bus.entry_rej      = r_entry_rej;
   assign bus.exit_ack       = r_exit_ack;
   assign bus.exit_err       = r_exit_err;
   assign bus.state          = r_state;
endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl: main instance LEVELS=2, SLOTS=2,
// DOOR_CYCLES=4, plus a LEVELS=3, SLOTS=1, DOOR_CYCLES=2 instance for
// out-of-range exit levels.
module tb_parking_lot_ctrl;
   logic clk;
   logic reset;

   parking_lot_if #(.LEVELS(2), .SLOTS(2)) if0 ();
   parking_lot_if #(.LEVELS(3), .SLOTS(1)) if1 ();

   parking_lot_ctrl #(.LEVELS(2), .SLOTS(2), .DOOR_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   parking_lot_ctrl #(.LEVELS(3), .SLOTS(1), .DOOR_CYCLES(2)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic       entry;
      logic       exit_r;
      logic       lvl;
      logic       eack;
      logic       erej;
      logic       xack;
      logic       xerr;
      logic       asg;
      logic [2:0] occ;
      logic [1:0] lf;
      logic       full;
      logic [1:0] st;
   } vec_t;

   localparam int NV = 13;
   vec_t vt [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counts door_open-high cycles from the current sample point (bounded).
   task automatic wait_door(input string tag, input int exp_cycles);
      int n;
      n = 0;
      while (if0.door_open && n < 20) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk({tag, "_door_cycles"}, n, exp_cycles);
      chk({tag, "_state_idle"}, 32'(if0.state), 0);
   endtask

   task automatic apply(input vec_t v, input int idx);
      string t;
      t = $sformatf("v%0d", idx);
      @(negedge clk);
      if0.entry_req  = v.entry;
      if0.exit_req   = v.exit_r;
      if0.exit_level = v.lvl;
      @(posedge clk);
      #1;
      if0.entry_req = 1'b0;
      if0.exit_req  = 1'b0;
      chk({t, "_entry_ack"}, 32'(if0.entry_ack), 32'(v.eack));
      chk({t, "_entry_rej"}, 32'(if0.entry_rej), 32'(v.erej));
      chk({t, "_exit_ack"},  32'(if0.exit_ack),  32'(v.xack));
      chk({t, "_exit_err"},  32'(if0.exit_err),  32'(v.xerr));
      chk({t, "_assigned"},  32'(if0.assigned_level), 32'(v.asg));
      chk({t, "_occupancy"}, 32'(if0.occupancy), 32'(v.occ));
      chk({t, "_level_full"}, 32'(if0.level_full), 32'(v.lf));
      chk({t, "_full"},      32'(if0.full), 32'(v.full));
      chk({t, "_state"},     32'(if0.state), 32'(v.st));
      chk({t, "_door"},      32'(if0.door_open), 32'(v.st != 2'd0));
      if (v.st != 2'd0) wait_door(t, 4);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (if0.state != 2'd0 && n < 20) begin
         n++;
         @(posedge clk);
         #1;
      end
      chk({tag, "_idle_bound"}, 32'(n < 20), 1);
   endtask

   initial begin
      //                entry exit  lvl   eack  erej  xack  xerr  asg   occ   lf      full  st
      vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'b00, 1'b0, 2'd1};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'b01, 1'b0, 2'd1};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 2'b01, 1'b0, 2'd1};
      vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 2'b11, 1'b1, 2'd1};
      // lot full: rejected, door stays closed, assigned level held
      vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 2'b11, 1'b1, 2'd0};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 2'b10, 1'b0, 2'd2};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 2'b11, 1'b1, 2'd1};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 2'b01, 1'b0, 2'd2};
      vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 2'b01, 1'b0, 2'd2};
      // level 1 now empty
      vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 2'b01, 1'b0, 2'd0};
      // simultaneous entry + exit: only the exit is processed
      vt[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 2'b00, 1'b0, 2'd2};
      vt[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 2'b01, 1'b0, 2'd1};
      vt[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 2'b01, 1'b0, 2'd1};

      // Reset
      reset          = 1'b1;
      if0.entry_req  = 1'b0;
      if0.exit_req   = 1'b0;
      if0.exit_level = '0;
      if1.entry_req  = 1'b0;
      if1.exit_req   = 1'b0;
      if1.exit_level = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_door",      32'(if0.door_open), 0);
      chk("rst_full",      32'(if0.full), 0);
      chk("rst_level_full", 32'(if0.level_full), 0);
      chk("rst_assigned",  32'(if0.assigned_level), 0);
      chk("rst_occupancy", 32'(if0.occupancy), 0);
      chk("rst_pulses",    32'({if0.entry_ack, if0.entry_rej, if0.exit_ack, if0.exit_err}), 0);
      chk("rst_state",     32'(if0.state), 0);

      // Three-level instance: exit_level 3 is out of range
      @(negedge clk);
      if1.entry_req = 1'b1;
      @(posedge clk);
      #1;
      if1.entry_req = 1'b0;
      chk("l3_entry_ack", 32'(if1.entry_ack), 1);
      chk("l3_occ1",      32'(if1.occupancy), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("l3_idle", 32'(if1.state), 0);
      @(negedge clk);
      if1.exit_req   = 1'b1;
      if1.exit_level = 2'd3;
      @(posedge clk);
      #1;
      if1.exit_req = 1'b0;
      chk("l3_oor_err",   32'(if1.exit_err), 1);
      chk("l3_oor_ack",   32'(if1.exit_ack), 0);
      chk("l3_oor_occ",   32'(if1.occupancy), 1);
      chk("l3_oor_state", 32'(if1.state), 0);
      @(negedge clk);
      if1.exit_req   = 1'b1;
      if1.exit_level = 2'd2;
      @(posedge clk);
      #1;
      if1.exit_req = 1'b0;
      chk("l3_empty_err", 32'(if1.exit_err), 1);
      chk("l3_empty_occ", 32'(if1.occupancy), 1);

      // Table-driven main sequence
      for (int i = 0; i < NV; i++) apply(vt[i], i);

      // Entry during an open door is dropped
      @(negedge clk);
      if0.exit_req   = 1'b1;
      if0.exit_level = 1'b1;
      @(posedge clk);
      #1;
      if0.exit_req = 1'b0;
      chk("busy_exit_ack", 32'(if0.exit_ack), 1);
      chk("busy_occ2",     32'(if0.occupancy), 2);
      @(negedge clk);
      if0.entry_req = 1'b1;
      @(posedge clk);
      #1;
      if0.entry_req = 1'b0;
      chk("busy_no_ack",   32'(if0.entry_ack), 0);
      chk("busy_no_rej",   32'(if0.entry_rej), 0);
      chk("busy_occ_held", 32'(if0.occupancy), 2);
      @(posedge clk);
      #1;
      chk("busy_no_ack_late", 32'(if0.entry_ack), 0);
      wait_idle("busy");
      chk("busy_occ_final", 32'(if0.occupancy), 2);

      // Asynchronous reset while the door is open with occupancy 3
      @(negedge clk);
      if0.entry_req = 1'b1;
      @(posedge clk);
      #1;
      if0.entry_req = 1'b0;
      chk("ar_entry_ack", 32'(if0.entry_ack), 1);
      chk("ar_assigned",  32'(if0.assigned_level), 1);
      chk("ar_occ3",      32'(if0.occupancy), 3);
      @(posedge clk);
      #3;
      chk("ar_door_before", 32'(if0.door_open), 1);
      reset = 1'b1;
      #1;
      chk("ar_door",      32'(if0.door_open), 0);
      chk("ar_occupancy", 32'(if0.occupancy), 0);
      chk("ar_state",     32'(if0.state), 0);
      chk("ar_level_full", 32'(if0.level_full), 0);
      chk("ar_assigned0", 32'(if0.assigned_level), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("ar_post_state", 32'(if0.state), 0);
      chk("ar_post_occ",   32'(if0.occupancy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
